// File: rtl/fml_half_splitter.sv
// Runs one 32-bit FML single-word transaction as two 16-bit memory accesses
// (upper half first), reassembling read data and bounding each access with a timeout.
`ifndef SDRAM_DEPTH
`define SDRAM_DEPTH 26
`endif

module fml_half_splitter #(
  parameter int adr_width = `SDRAM_DEPTH,
  parameter int TIMEOUT   = 255
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [adr_width-1:0] fml_adr,
  input  logic                 fml_stb,
  input  logic                 fml_we,
  input  logic [3:0]           fml_sel,
  input  logic [31:0]          fml_di,
  output logic                 fml_ack,
  output logic [31:0]          fml_do,
  output logic                 fml_err,
  output logic                 busy,
  output logic [adr_width-1:0] mem_adr,
  output logic                 mem_stb,
  output logic                 mem_we,
  output logic [1:0]           mem_sel,
  output logic [15:0]          mem_dw,
  input  logic [15:0]          mem_dr,
  input  logic                 mem_ack
);
  typedef enum logic [2:0] {IDLE, HI, GAP, LO, DONE} state_t;

  state_t               state;
  logic [adr_width-1:2] adr;
  logic                 we;
  logic [3:0]           sel;
  logic [31:0]          di;
  logic [15:0]          rdata_hi;
  logic [15:0]          cnt;
  logic                 expire;
  logic                 adr_unused;

  // Byte-lane bits of the FML address never reach the memory side.
  assign adr_unused = ^fml_adr[1:0];

  // Only meaningful in HI/LO, where mem_stb is always high; an ack in the same cycle wins.
  assign expire = (TIMEOUT != 0) && (cnt == 16'(TIMEOUT - 1)) && !mem_ack;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      adr      <= '0;
      we       <= 1'b0;
      sel      <= '0;
      di       <= '0;
      rdata_hi <= '0;
      cnt      <= '0;
      fml_ack  <= 1'b0;
      fml_do   <= '0;
      fml_err  <= 1'b0;
      busy     <= 1'b0;
      mem_adr  <= '0;
      mem_stb  <= 1'b0;
      mem_we   <= 1'b0;
      mem_sel  <= '0;
      mem_dw   <= '0;
    end else begin
      fml_ack <= 1'b0;
      fml_err <= 1'b0;
      case (state)
        IDLE: if (fml_stb) begin
          adr  <= fml_adr[adr_width-1:2];
          we   <= fml_we;
          sel  <= fml_sel;
          di   <= fml_di;
          busy <= 1'b1;
          cnt  <= '0;
          if (!fml_we || fml_sel[3:2] != 2'b00) begin
            state   <= HI;
            mem_stb <= 1'b1;
            mem_we  <= fml_we;
            mem_adr <= {fml_adr[adr_width-1:2], 2'b00};
            mem_sel <= fml_we ? fml_sel[3:2] : 2'b11;
            mem_dw  <= fml_di[31:16];
          end else if (fml_sel[1:0] != 2'b00) begin
            state   <= LO;
            mem_stb <= 1'b1;
            mem_we  <= 1'b1;
            mem_adr <= {fml_adr[adr_width-1:2], 2'b10};
            mem_sel <= fml_sel[1:0];
            mem_dw  <= fml_di[15:0];
          end else begin
            // Empty write: nothing to do on the memory side.
            state   <= DONE;
            fml_ack <= 1'b1;
          end
        end
        HI, LO: begin
          if (mem_ack || expire) begin
            mem_stb <= 1'b0;
            mem_adr <= '0;
            mem_sel <= '0;
            mem_dw  <= '0;
          end
          if (mem_ack) begin
            if (state == HI && !we) rdata_hi <= mem_dr;
            if (state == LO && !we) fml_do <= {rdata_hi, mem_dr};
            if (state == HI && !(we && sel[1:0] == 2'b00)) begin
              state <= GAP;
            end else begin
              state   <= DONE;
              fml_ack <= 1'b1;
              mem_we  <= 1'b0;
            end
          end else if (expire) begin
            state    <= DONE;
            fml_ack  <= 1'b1;
            fml_err  <= 1'b1;
            fml_do   <= '0;
            rdata_hi <= '0;
            mem_we   <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          state   <= LO;
          cnt     <= '0;
          mem_stb <= 1'b1;
          mem_adr <= {adr, 2'b10};
          mem_sel <= we ? sel[1:0] : 2'b11;
          mem_dw  <= di[15:0];
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fml_half_splitter.sv
// Randomized self-checking bench: a behavioural 16-bit memory responder plus a
// transaction-level reference model of the expected accesses, latency and results.
module tb_fml_half_splitter;
  localparam int AW  = 16;
  localparam int TMO = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [AW-1:0] fml_adr;
  logic          fml_stb, fml_we;
  logic [3:0]    fml_sel;
  logic [31:0]   fml_di;
  logic          fml_ack, fml_err, busy;
  logic [31:0]   fml_do;
  logic [AW-1:0] mem_adr;
  logic          mem_stb, mem_we;
  logic [1:0]    mem_sel;
  logic [15:0]   mem_dw, mem_dr;
  logic          mem_ack;

  fml_half_splitter #(.adr_width(AW), .TIMEOUT(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_sel(fml_sel),
    .fml_di(fml_di), .fml_ack(fml_ack), .fml_do(fml_do), .fml_err(fml_err),
    .busy(busy), .mem_adr(mem_adr), .mem_stb(mem_stb), .mem_we(mem_we),
    .mem_sel(mem_sel), .mem_dw(mem_dw), .mem_dr(mem_dr), .mem_ack(mem_ack)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [15:0] adr;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] dw;
  } acc_t;

  int          errors = 0, checks = 0;
  logic [15:0] dev_mem [0:511];
  logic [15:0] ref_mem [0:511];
  int          ack_lat = 0;
  int          stb_run = 0, last_run = 0, lo_run = 0;
  bit          seen_hi = 0;
  acc_t        got_q[$];
  int          gap_q[$];
  logic [31:0] last_do = '0;

  // Memory responder: acks once mem_stb has been high for ack_lat+1 cycles (never if ack_lat < 0).
  initial begin
    mem_ack = 1'b0;
    mem_dr  = '0;
    forever begin
      @(negedge sys_clk);
      if (mem_stb) begin
        if (seen_hi && lo_run > 0) gap_q.push_back(lo_run);
        seen_hi = 1;
        lo_run  = 0;
        stb_run++;
        mem_ack = (ack_lat >= 0) && (stb_run > ack_lat);
        if (mem_ack) begin
          acc_t e;
          e.adr = mem_adr; e.we = mem_we; e.sel = mem_sel; e.dw = mem_dw;
          got_q.push_back(e);
          mem_dr = dev_mem[mem_adr[9:1]];
          if (mem_we && mem_sel[1]) dev_mem[mem_adr[9:1]][15:8] = mem_dw[15:8];
          if (mem_we && mem_sel[0]) dev_mem[mem_adr[9:1]][7:0]  = mem_dw[7:0];
        end
      end else begin
        if (stb_run > 0) last_run = stb_run;
        stb_run = 0;
        lo_run++;
        mem_ack = 1'b0;
        mem_dr  = 16'($urandom);
      end
    end
  end

  task automatic clear_logs();
    got_q.delete();
    gap_q.delete();
    seen_hi = 0;
    last_run = 0;
  endtask

  // One transaction, checked against the reference; returns at the negedge after fml_ack.
  task automatic do_txn(input string nm, input logic [15:0] a, input logic w,
                        input logic [3:0] s, input logic [31:0] d, input int lat);
    acc_t        exp_q[$];
    acc_t        e;
    int          n, exp_cyc, cyc;
    bit          tmo;
    logic        exp_err;
    logic [31:0] exp_do;
    logic [15:0] base;
    base = a & 16'hfffc;
    if (!w || s[3:2] != 2'b00) begin
      e.adr = base; e.we = w; e.sel = w ? s[3:2] : 2'b11; e.dw = d[31:16];
      exp_q.push_back(e);
    end
    if (!w || s[1:0] != 2'b00) begin
      e.adr = base | 16'h2; e.we = w; e.sel = w ? s[1:0] : 2'b11; e.dw = d[15:0];
      exp_q.push_back(e);
    end
    n   = exp_q.size();
    tmo = (n > 0) && (lat < 0 || lat >= TMO);
    if (tmo) begin
      exp_cyc = 1 + TMO; exp_err = 1'b1; exp_do = '0;
      exp_q.delete();
    end else begin
      exp_cyc = 1 + n * (1 + lat) + ((n == 2) ? 1 : 0);
      exp_err = 1'b0;
      foreach (exp_q[i]) if (w) begin
        if (exp_q[i].sel[1]) ref_mem[exp_q[i].adr[9:1]][15:8] = exp_q[i].dw[15:8];
        if (exp_q[i].sel[0]) ref_mem[exp_q[i].adr[9:1]][7:0]  = exp_q[i].dw[7:0];
      end
      exp_do = w ? last_do : {ref_mem[base[9:1]], ref_mem[base[9:1] + 9'd1]};
    end
    last_do = exp_do;

    clear_logs();
    ack_lat = lat;
    fml_adr = a; fml_we = w; fml_sel = s; fml_di = d; fml_stb = 1'b1;
    cyc = 0;
    do begin
      @(negedge sys_clk);
      cyc++;
    end while (!fml_ack && cyc < 200);
    fml_stb = 1'b0;

    checks++;
    if (cyc != exp_cyc) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, exp_cyc);
    end
    checks++;
    if (fml_do !== exp_do) begin
      errors++; $display("FAIL %s fml_do: got %h want %h", nm, fml_do, exp_do);
    end
    checks++;
    if (fml_err !== exp_err) begin
      errors++; $display("FAIL %s fml_err: got %b want %b", nm, fml_err, exp_err);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s access count: got %0d want %0d", nm, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i].adr !== exp_q[i].adr || got_q[i].we !== exp_q[i].we ||
            got_q[i].sel !== exp_q[i].sel || (w && got_q[i].dw !== exp_q[i].dw)) begin
          errors++;
          $display("FAIL %s access%0d: got adr=%h we=%b sel=%b dw=%h want adr=%h we=%b sel=%b dw=%h",
                   nm, i, got_q[i].adr, got_q[i].we, got_q[i].sel, got_q[i].dw,
                   exp_q[i].adr, exp_q[i].we, exp_q[i].sel, exp_q[i].dw);
        end
      end
    end
    @(negedge sys_clk);
    checks++;
    if (fml_ack !== 1'b0 || fml_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s post-ack: got ack=%b err=%b busy=%b want 0 0 0", nm, fml_ack, fml_err, busy);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({fml_ack, fml_err, busy, mem_stb, mem_we, mem_sel, mem_adr, mem_dw, fml_do} !== '0) begin
      errors++; $display("FAIL reset outputs: got ack=%b err=%b busy=%b stb=%b do=%h want all 0",
                         fml_ack, fml_err, busy, mem_stb, fml_do);
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_read();
    dev_mem[9'h080] = 16'hABCD; ref_mem[9'h080] = 16'hABCD;
    dev_mem[9'h081] = 16'h1234; ref_mem[9'h081] = 16'h1234;
    do_txn("read_0x100", 16'h0100, 1'b0, 4'hf, 32'h0, 1);
    checks++;
    if (fml_do !== 32'hABCD1234) begin
      errors++; $display("FAIL read_0x100 value: got %h want abcd1234", fml_do);
    end
  endtask

  task automatic test_write_full();
    do_txn("write_full", 16'h0020, 1'b1, 4'hf, 32'hDEADBEEF, 0);
    checks++;
    if (gap_q.size() != 1 || gap_q[0] != 1) begin
      errors++; $display("FAIL write_full gap: got %0d gaps (first %0d) want one gap of 1",
                         gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1);
    end
    checks++;
    if (dev_mem[9'h010] !== 16'hDEAD || dev_mem[9'h011] !== 16'hBEEF) begin
      errors++; $display("FAIL write_full mem: got %h %h want dead beef", dev_mem[9'h010], dev_mem[9'h011]);
    end
  endtask

  task automatic test_write_partial();
    do_txn("write_lo", 16'h0040, 1'b1, 4'b0011, 32'hDEADBEEF, 0);
    do_txn("write_hi", 16'h0044, 1'b1, 4'b1100, 32'hDEADBEEF, 0);
    do_txn("write_none", 16'h0048, 1'b1, 4'b0000, 32'hDEADBEEF, 0);
    do_txn("write_byte", 16'h004c, 1'b1, 4'b0100, 32'h11223344, 1);
  endtask

  task automatic test_timeout();
    do_txn("timeout_read", 16'h0060, 1'b0, 4'hf, 32'h0, -1);
    checks++;
    if (last_run != TMO) begin
      errors++; $display("FAIL timeout stb_len: got %0d want %0d", last_run, TMO);
    end
    do_txn("ack_on_expiry", 16'h0064, 1'b0, 4'hf, 32'h0, TMO - 1);
    do_txn("timeout_write", 16'h0068, 1'b1, 4'hf, 32'h55AA55AA, -1);
  endtask

  task automatic test_reset_mid();
    bit saw_ack;
    clear_logs();
    ack_lat = 2;
    fml_adr = 16'h0140; fml_we = 1'b0; fml_sel = 4'hf; fml_stb = 1'b1;
    repeat (5) @(negedge sys_clk);
    checks++;
    if (mem_stb !== 1'b1 || mem_adr !== 16'h0142) begin
      errors++; $display("FAIL rst_mid in_lo: got stb=%b adr=%h want 1 0142", mem_stb, mem_adr);
    end
    sys_rst = 1'b1; fml_stb = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    checks++;
    if ({fml_ack, fml_err, busy, mem_stb, mem_we, mem_sel, mem_adr, mem_dw, fml_do} !== '0) begin
      errors++; $display("FAIL rst_mid outputs: got ack=%b busy=%b stb=%b do=%h want all 0",
                         fml_ack, busy, mem_stb, fml_do);
    end
    last_do = '0;
    saw_ack = 0;
    repeat (6) begin
      @(negedge sys_clk);
      if (fml_ack) saw_ack = 1;
    end
    checks++;
    if (saw_ack) begin
      errors++; $display("FAIL rst_mid stray_ack: got ack want none");
    end
    do_txn("after_reset", 16'h0140, 1'b0, 4'hf, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit extra;
    logic [31:0] exp_a, exp_b;
    exp_a = {ref_mem[9'h0c0], ref_mem[9'h0c1]};
    exp_b = {ref_mem[9'h0c4], ref_mem[9'h0c5]};
    clear_logs();
    ack_lat = 0;
    fml_adr = 16'h0180; fml_we = 1'b0; fml_sel = 4'hf; fml_stb = 1'b1;
    cyc = 0;
    do begin @(negedge sys_clk); cyc++; end while (!fml_ack && cyc < 100);
    checks++;
    if (cyc != 4 || fml_do !== exp_a) begin
      errors++; $display("FAIL b2b first: got cyc=%0d do=%h want 4 %h", cyc, fml_do, exp_a);
    end
    fml_adr = 16'h0188;
    cyc = 0;
    do begin @(negedge sys_clk); cyc++; end while (!fml_ack && cyc < 100);
    fml_stb = 1'b0;
    checks++;
    if (cyc != 5 || fml_do !== exp_b) begin
      errors++; $display("FAIL b2b second: got cyc=%0d do=%h want 5 %h", cyc, fml_do, exp_b);
    end
    last_do = exp_b;
    extra = 0;
    repeat (8) begin
      @(negedge sys_clk);
      if (fml_ack || mem_stb) extra = 1;
    end
    checks++;
    if (extra || got_q.size() != 4) begin
      errors++; $display("FAIL b2b duplicate: got extra=%b accesses=%0d want 0 4", extra, got_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int lat;
      lat = ($urandom_range(0, 7) == 0) ? TMO + 1 : int'($urandom_range(0, 2));
      do_txn($sformatf("rand%0d", i), 16'($urandom_range(0, 1023)), 1'($urandom),
             4'($urandom), $urandom, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      dev_mem[i] = 16'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    sys_rst = 1'b1; fml_stb = 1'b0; fml_we = 1'b0; fml_sel = '0; fml_di = '0; fml_adr = '0;
    @(negedge sys_clk);
    test_reset();
    test_read();
    test_write_full();
    test_write_partial();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
